// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns CPU byte/half/word requests into aligned big-endian word accesses.
// Optional DM_BOUNDS_CHECK_EN: reject addresses with nonzero bits above ADDR_W instead of wrapping.
module dm_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dm_cs,
    output logic        dm_wr,
    output logic        dm_rd,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_in,
    input  logic [31:0] dm_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD     = 3'd1;
    localparam logic [2:0] S_ST     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state_q,  state_d;
    logic              we_q,     we_d;
    logic [1:0]        size_q,   size_d;
    logic              sext_q,   sext_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic [31:0]       merge_q,  merge_d;

    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] merge_wdata;
    logic [31:0] word_addr;

    assign misaligned = (size == 2'b11)
                     || ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr[1:0] != 2'b00));

`ifdef DM_BOUNDS_CHECK_EN
    assign out_of_range = |addr[31:ADDR_W];
`else
    assign out_of_range = 1'b0;
`endif

    assign word_addr = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W-1:2], 2'b00};

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        load_byte = dm_out[7:0];
        case (addr_q[1:0])
            2'd0:    load_byte = dm_out[31:24];
            2'd1:    load_byte = dm_out[23:16];
            2'd2:    load_byte = dm_out[15:8];
            default: load_byte = dm_out[7:0];
        endcase
        load_half = addr_q[1] ? dm_out[15:0] : dm_out[31:16];
        case (size_q)
            SZ_BYTE: load_value = {{24{sext_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_value = {{16{sext_q & load_half[15]}}, load_half};
            default: load_value = dm_out;
        endcase
    end

    // Store merge: each lane takes new data only if the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (size_q == SZ_BYTE) && (addr_q[1:0] == LANE);
            assign half_hit = (size_q == SZ_HALF) && (addr_q[1] == LANE[1]);
            assign merge_wdata[31-8*gi -: 8] =
                byte_hit ? wdata_q[7:0] :
                half_hit ? (LANE[0] ? wdata_q[7:0] : wdata_q[15:8]) :
                           merge_q[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sext;
                    addr_d  = addr[ADDR_W-1:0];
                    wdata_d = wdata;
                    if (misaligned || out_of_range) state_d = S_ERR;
                    else if (!we)                   state_d = S_LD;
                    else if (size == SZ_WORD)       state_d = S_ST;
                    else                            state_d = S_RMW_RD;
                end
            end
            S_LD: begin
                rdata_d = load_value;
                state_d = S_DONE;
            end
            S_ST:     state_d = S_DONE;
            S_RMW_RD: begin
                merge_d = dm_out;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory controls are gated by reset so an edge that samples reset can never write.
    always_comb begin
        dm_cs   = 1'b0;
        dm_wr   = 1'b0;
        dm_rd   = 1'b0;
        dm_in   = 32'd0;
        dm_addr = 32'd0;
        if (!reset) begin
            case (state_q)
                S_LD, S_RMW_RD: begin
                    dm_cs = 1'b1;
                    dm_rd = 1'b1;
                end
                S_ST: begin
                    dm_cs = 1'b1;
                    dm_wr = 1'b1;
                    dm_in = wdata_q;
                end
                S_RMW_WR: begin
                    dm_cs = 1'b1;
                    dm_wr = 1'b1;
                    dm_in = merge_wdata;
                end
                default: ;
            endcase
            if (dm_cs) dm_addr = word_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = !reset && ((state_q == S_DONE) || (state_q == S_ERR));
    assign err   = !reset && (state_q == S_ERR);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: byte-addressed reference memory predicts results,
// a negedge monitor pops expectations on every done pulse.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, err;
    logic [31:0] rdata;
    logic        dm_cs, dm_wr, dm_rd;
    logic [31:0] dm_addr, dm_in, dm_out;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
        .dm_addr(dm_addr), .dm_in(dm_in), .dm_out(dm_out)
    );

    // 4Kx8 big-endian memory: combinational word read, word write on posedge
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [11:0] ma;
    assign ma     = {dm_addr[11:2], 2'b00};
    assign dm_out = {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]};

    always @(posedge clk) begin
        if (dm_cs && dm_wr) begin
            mem[ma]         <= dm_in[31:24];
            mem[ma + 12'd1] <= dm_in[23:16];
            mem[ma + 12'd2] <= dm_in[15:8];
            mem[ma + 12'd3] <= dm_in[7:0];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cs, n_rd, n_wr;
    logic [31:0] model_rdata = 32'd0;

    always @(negedge clk) begin
        if (reset) begin
            n_cs = 0; n_rd = 0; n_wr = 0;
        end else begin
            check("rd_wr_excl", {31'b0, dm_rd & dm_wr}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.tag, "/err"},   {31'b0, err}, {31'b0, mon_e.exp_err});
                    check({mon_e.tag, "/rdata"}, rdata, mon_e.exp_rdata);
                    check({mon_e.tag, "/lat"},   32'(cyc - mon_e.acc_cyc), 32'(mon_e.exp_lat));
                    check({mon_e.tag, "/rd"},    32'(n_rd), 32'(mon_e.exp_rd));
                    check({mon_e.tag, "/wr"},    32'(n_wr), 32'(mon_e.exp_wr));
                    check({mon_e.tag, "/cs"},    32'(n_cs), 32'(mon_e.exp_rd + mon_e.exp_wr));
                    $display("txn %-12s err=%0b rdata=%h lat=%0d rd=%0d wr=%0d",
                             mon_e.tag, err, rdata, cyc - mon_e.acc_cyc, n_rd, n_wr);
                end
                n_cs = 0; n_rd = 0; n_wr = 0;
            end else begin
                n_cs += int'(dm_cs);
                n_rd += int'(dm_rd);
                n_wr += int'(dm_wr);
            end
        end
    end

    task automatic wait_ready();
        @(posedge clk); #1;
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk); #1;
        end
        check("ready_wait", {31'b0, ready}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic        bad;
        logic [11:0] a12;
        logic [7:0]  b;
        logic [15:0] h;
        a12 = a[11:0];
        bad = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
`ifdef DM_BOUNDS_CHECK_EN
        bad = bad || (a[31:12] != 20'd0);
`endif
        e.tag     = tag;
        e.exp_err = bad;
        e.exp_lat = bad ? 0 : (!w || sz == 2'b10) ? 1 : 2;
        e.exp_rd  = bad ? 0 : (!w || sz != 2'b10) ? 1 : 0;
        e.exp_wr  = (bad || !w) ? 0 : 1;
        if (!bad && !w) begin
            b = ref_mem[a12];
            h = {ref_mem[a12], ref_mem[a12 + 12'd1]};
            case (sz)
                2'b00:   model_rdata = sx ? {{24{b[7]}}, b} : {24'd0, b};
                2'b01:   model_rdata = sx ? {{16{h[15]}}, h} : {16'd0, h};
                default: model_rdata = {ref_mem[a12], ref_mem[a12 + 12'd1],
                                        ref_mem[a12 + 12'd2], ref_mem[a12 + 12'd3]};
            endcase
        end
        if (!bad && w) begin
            case (sz)
                2'b00: ref_mem[a12] = wd[7:0];
                2'b01: begin
                    ref_mem[a12]         = wd[15:8];
                    ref_mem[a12 + 12'd1] = wd[7:0];
                end
                default: begin
                    ref_mem[a12]         = wd[31:24];
                    ref_mem[a12 + 12'd1] = wd[23:16];
                    ref_mem[a12 + 12'd2] = wd[15:8];
                    ref_mem[a12 + 12'd3] = wd[7:0];
                end
            endcase
        end
        e.exp_rdata = model_rdata;
        wait_ready();
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check({tag, "/timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_mem(input string tag, input logic [11:0] a, input logic [31:0] exp);
        check(tag, {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]}, exp);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'd0;
            ref_mem[i] = 8'd0;
        end
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'b0, dm_cs}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        do_req("st_w_000", 1'b1, 2'b10, 1'b0, 32'h000, 32'hCAFEF00D);
        do_req("st_w_010", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
        check_mem("mem_010", 12'h010, 32'hDEADBEEF);
        do_req("ld_w_010", 1'b0, 2'b10, 1'b0, 32'h010, 32'd0);
        check("tp_ld_word", rdata, 32'hDEADBEEF);

        do_req("st_w_020", 1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF7F01);
        do_req("ld_b_021s", 1'b0, 2'b00, 1'b1, 32'h021, 32'd0);
        check("tp_byte_sx", rdata, 32'hFFFFFFFF);
        do_req("ld_b_023z", 1'b0, 2'b00, 1'b0, 32'h023, 32'd0);
        check("tp_byte_zx", rdata, 32'h00000001);
        do_req("ld_h_020s", 1'b0, 2'b01, 1'b1, 32'h020, 32'd0);
        check("tp_half_sx", rdata, 32'hFFFF80FF);
        do_req("ld_h_022z", 1'b0, 2'b01, 1'b0, 32'h022, 32'd0);
        check("tp_half_zx", rdata, 32'h00007F01);

        do_req("st_w_030", 1'b1, 2'b10, 1'b0, 32'h030, 32'h11223344);
        do_req("st_b_032", 1'b1, 2'b00, 1'b0, 32'h032, 32'h000000AA);
        check_mem("tp_rmw_byte", 12'h030, 32'h1122AA44);
        check("st_keeps_rdata", rdata, 32'h00007F01);

        do_req("mis_ld_w005", 1'b0, 2'b10, 1'b0, 32'h005, 32'd0);
        do_req("mis_st_h007", 1'b1, 2'b01, 1'b0, 32'h007, 32'h0000BEEF);
        do_req("mis_size11",  1'b0, 2'b11, 1'b0, 32'h000, 32'd0);
        check("mis_rdata", rdata, 32'h00007F01);
        check_mem("mis_mem_004", 12'h004, 32'h00000000);

        do_req("bound_1000", 1'b0, 2'b10, 1'b0, 32'h00001000, 32'd0);
`ifdef DM_BOUNDS_CHECK_EN
        check("tp_bound_err", rdata, 32'h00007F01);
`else
        check("tp_wrap", rdata, 32'hCAFEF00D);
`endif

        // Reset while the RMW write cycle is on the bus.
        do_req("st_w_040", 1'b1, 2'b10, 1'b0, 32'h040, 32'h55667788);
        wait_ready();
        req = 1'b1; we = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h042; wdata = 32'h00001234;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rmw_wr_phase", {31'b0, dm_wr}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_gates_wr", {31'b0, dm_wr}, 32'd0);
        check("rst_gates_cs", {31'b0, dm_cs}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_mem("tp_rst_mem", 12'h040, 32'h55667788);
        check("tp_rst_ready", {31'b0, ready}, 32'd1);
        check("tp_rst_rdata", rdata, 32'd0);
        check("tp_rst_ctrl", {29'b0, dm_cs, dm_rd, dm_wr}, 32'd0);
        model_rdata = 32'd0;
        $display("txn %-12s reset mid-RMW, memory kept", "rst_rmw_042");

        for (int n = 0; n < 30; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 63)) * 4;
            if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
            if (sz == 2'b01) a = a + 32'($urandom_range(0, 1)) * 2;
            do_req($sformatf("rnd_%0d", n), 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int w = 0; w < 64; w++) begin
            logic [11:0] a;
            a = 12'h100 + 12'(w * 4);
            check_mem($sformatf("rnd_mem_%03h", a), a,
                      {ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2], ref_mem[a + 12'd3]});
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
